// File: rtl/rgbw_pwm_pkg.sv
// Shared constants and types for the four-channel RGBW PWM core.
package rgbw_pwm_pkg;

  localparam int PWM_WIDTH = 8;
  localparam int PWM_MAX   = 2**PWM_WIDTH - 1;

  localparam int NUM_CH = 4;
  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;
  localparam int CH_W   = 3;

  typedef logic [PWM_WIDTH-1:0] duty_t;

endpackage

// File: rtl/rgbw_pwm_core_if.sv
// Control/status bundle between the PWM core and its host: tick input,
// duty loading handshake and the four LED outputs.
interface rgbw_pwm_core_if;
  import rgbw_pwm_pkg::*;

  logic  clkPresc;
  logic  enable;
  duty_t dutyR;
  duty_t dutyG;
  duty_t dutyB;
  duty_t dutyW;
  logic  dutyLoad;
  logic  loadPending;
  logic  periodStart;
  logic  pwmR;
  logic  pwmG;
  logic  pwmB;
  logic  pwmW;

  modport master (
    output clkPresc, enable, dutyR, dutyG, dutyB, dutyW, dutyLoad,
    input  loadPending, periodStart, pwmR, pwmG, pwmB, pwmW
  );

  modport slave (
    input  clkPresc, enable, dutyR, dutyG, dutyB, dutyW, dutyLoad,
    output loadPending, periodStart, pwmR, pwmG, pwmB, pwmW
  );

endinterface

// File: rtl/rgbw_pwm_core_channel.sv
// One PWM channel: shadow duty, active duty and the registered compare output.
module pwm_channel
  import rgbw_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  duty_t counter,
  input  duty_t duty,
  input  logic  dutyLoad,
  input  logic  apply,
  input  logic  enable,
  output logic  pwm
);

  duty_t shadow;
  duty_t active;

  // Apply reads the shadow before a same-cycle load overwrites it, so a
  // load on the boundary cycle lands in the following period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (dutyLoad) shadow <= duty;
      if (apply)    active <= shadow;
      pwm <= enable & (counter < active);
    end
  end

endmodule

// File: rtl/rgbw_pwm_core.sv
// Four-channel PWM generator ticked by a prescaled strobe in the clk domain,
// with double-buffered duties that switch only at period boundaries.
module rgbw_pwm_core
  import rgbw_pwm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  rgbw_pwm_core_if.slave bus
);

  localparam duty_t CNT_LAST = duty_t'(PWM_MAX - 1);

  logic  armed;
  logic  prescPrev;
  logic  tick;
  logic  boundary;
  logic  apply;
  logic  pendingQ;
  logic  startQ;
  duty_t counter;
  duty_t duty [NUM_CH];
  logic  pwm  [NUM_CH];

  // armed blocks a tick on the first edge after reset release, so a
  // prescaler already high at release cannot count immediately.
  assign tick     = armed & bus.clkPresc & ~prescPrev;
  assign boundary = tick & bus.enable & (counter == CNT_LAST);
  assign apply    = boundary & pendingQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed     <= 1'b0;
      prescPrev <= 1'b0;
      counter   <= '0;
      startQ    <= 1'b0;
      pendingQ  <= 1'b0;
    end else begin
      armed     <= 1'b1;
      prescPrev <= bus.clkPresc;
      startQ    <= boundary;
      if (!bus.enable) begin
        counter <= '0;
      end else if (tick) begin
        counter <= boundary ? '0 : counter + duty_t'(1);
      end
      // A load on the boundary cycle keeps pending set for the next period.
      if (bus.dutyLoad) begin
        pendingQ <= 1'b1;
      end else if (boundary) begin
        pendingQ <= 1'b0;
      end
    end
  end

  assign duty[CH_R] = bus.dutyR;
  assign duty[CH_G] = bus.dutyG;
  assign duty[CH_B] = bus.dutyB;
  assign duty[CH_W] = bus.dutyW;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_channel u_ch (
      .clk      (clk),
      .reset    (reset),
      .counter  (counter),
      .duty     (duty[ch]),
      .dutyLoad (bus.dutyLoad),
      .apply    (apply),
      .enable   (bus.enable),
      .pwm      (pwm[ch])
    );
  end

  assign bus.loadPending = pendingQ;
  assign bus.periodStart = startQ;
  assign bus.pwmR        = pwm[CH_R];
  assign bus.pwmG        = pwm[CH_G];
  assign bus.pwmB        = pwm[CH_B];
  assign bus.pwmW        = pwm[CH_W];

endmodule

// File: tb/tb_rgbw_pwm_core.sv
// Self-checking bench for rgbw_pwm_core: measures whole periods against a
// duty/shadow/pending model driven by a /6 prescaler.
module tb_rgbw_pwm_core;
  import rgbw_pwm_pkg::*;

  localparam int CLK_PER_TICK = 6;
  localparam int PERIOD_CLK   = PWM_MAX * CLK_PER_TICK;

  logic clk;
  logic reset;
  rgbw_pwm_core_if bus();

  rgbw_pwm_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ticks    = 0;

  int exp_active [NUM_CH];
  int exp_shadow [NUM_CH];
  bit exp_pending;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divider toggling every 3 clk; ticks counts the edges that consume a rise.
  initial begin
    int cnt;
    bit rose;
    cnt  = 0;
    rose = 1'b0;
    bus.clkPresc = 1'b0;
    forever begin
      @(posedge clk);
      if (rose) ticks++;
      rose = 1'b0;
      #1;
      cnt++;
      if (cnt == 3) begin
        cnt = 0;
        bus.clkPresc = ~bus.clkPresc;
        if (bus.clkPresc) rose = 1'b1;
      end
    end
  end

  function automatic logic pwm_bit(input int ch);
    case (ch)
      CH_R:    return bus.pwmR;
      CH_G:    return bus.pwmG;
      CH_B:    return bus.pwmB;
      default: return bus.pwmW;
    endcase
  endfunction

  function automatic int rand_duty();
    int sel;
    sel = int'($urandom_range(0, 4));
    if (sel == 0) return 0;
    if (sel == 1) return PWM_MAX;
    return int'($urandom_range(1, PWM_MAX - 1));
  endfunction

  function automatic void model_boundary();
    if (exp_pending) begin
      exp_active  = exp_shadow;
      exp_pending = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_active[ch] = 0;
      exp_shadow[ch] = 0;
    end
    exp_pending = 1'b0;
  endfunction

  task automatic applyStimulus(input int r, input int g, input int b, input int w);
    bus.dutyR    = duty_t'(r);
    bus.dutyG    = duty_t'(g);
    bus.dutyB    = duty_t'(b);
    bus.dutyW    = duty_t'(w);
    bus.dutyLoad = 1'b1;
    exp_shadow   = '{r, g, b, w};
    exp_pending  = 1'b1;
    @(negedge clk);
    bus.dutyLoad = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * PERIOD_CLK && !seen; i++) begin
      @(negedge clk);
      if (bus.periodStart) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s: periodStart not seen within %0d clk", name, 2 * PERIOD_CLK);
    end else begin
      model_boundary();
    end
  endtask

  // Starting on a periodStart sample, collects one full period of outputs.
  task automatic measure(output int hi [NUM_CH], output int len);
    bit done;
    done = 1'b0;
    len  = 0;
    for (int ch = 0; ch < NUM_CH; ch++) hi[ch] = 0;
    while (!done && len < 2 * PERIOD_CLK) begin
      @(negedge clk);
      len++;
      for (int ch = 0; ch < NUM_CH; ch++) hi[ch] += int'(pwm_bit(ch));
      if (bus.periodStart) done = 1'b1;
    end
    if (done) model_boundary();
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.enable   = 1'b0;
    bus.dutyLoad = 1'b0;
    bus.dutyR    = '0;
    bus.dutyG    = '0;
    bus.dutyB    = '0;
    bus.dutyW    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (pwm_bit(ch) !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_pwm ch%0d: got %b expected 0", ch, pwm_bit(ch));
      end
    end
    checks++;
    if (bus.loadPending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_loadPending: got %b expected 0", bus.loadPending);
    end
    checks++;
    if (bus.periodStart !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_periodStart: got %b expected 0", bus.periodStart);
    end
    reset      = 1'b1;
    bus.enable = 1'b1;
  endtask

  task automatic test_idle();
    int hi [NUM_CH];
    int len;
    wait_ps("idle_first");
    for (int p = 0; p < 2; p++) begin
      measure(hi, len);
      checks++;
      if (len !== PERIOD_CLK) begin
        failures++;
        $display("[TB] FAIL idle_period p%0d: got %0d clk expected %0d", p, len, PERIOD_CLK);
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        checks++;
        if (hi[ch] !== 0) begin
          failures++;
          $display("[TB] FAIL idle_hi p%0d ch%0d: got %0d expected 0", p, ch, hi[ch]);
        end
      end
      checks++;
      if (bus.loadPending !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_loadPending: got %b expected 0", bus.loadPending);
      end
    end
  endtask

  task automatic test_basic_load();
    int hi [NUM_CH];
    int snap [NUM_CH];
    int len;
    repeat (100) @(negedge clk);
    applyStimulus(64, 0, PWM_MAX, 128);
    checks++;
    if (bus.loadPending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_pending_set: got %b expected 1", bus.loadPending);
    end
    wait_ps("basic_boundary");
    checks++;
    if (bus.loadPending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_pending_clear: got %b expected 0", bus.loadPending);
    end
    snap = exp_active;
    measure(hi, len);
    checks++;
    if (len !== PERIOD_CLK) begin
      failures++;
      $display("[TB] FAIL basic_period: got %0d clk expected %0d", len, PERIOD_CLK);
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (hi[ch] !== snap[ch] * CLK_PER_TICK) begin
        failures++;
        $display("[TB] FAIL basic_hi ch%0d: got %0d expected %0d", ch, hi[ch], snap[ch] * CLK_PER_TICK);
      end
    end
  endtask

  task automatic test_random_loads();
    int hi [NUM_CH];
    int snap [NUM_CH];
    int len;
    for (int it = 0; it < 3; it++) begin
      repeat ($urandom_range(5, 1400)) @(negedge clk);
      applyStimulus(rand_duty(), rand_duty(), rand_duty(), rand_duty());
      wait_ps("random_boundary");
      snap = exp_active;
      measure(hi, len);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        checks++;
        if (hi[ch] !== snap[ch] * CLK_PER_TICK) begin
          failures++;
          $display("[TB] FAIL random_hi it%0d ch%0d duty %0d: got %0d expected %0d",
                   it, ch, snap[ch], hi[ch], snap[ch] * CLK_PER_TICK);
        end
      end
    end
  endtask

  task automatic test_last_load_wins();
    int hi [NUM_CH];
    int snap [NUM_CH];
    int len;
    repeat (200) @(negedge clk);
    applyStimulus(10, rand_duty(), rand_duty(), PWM_MAX);
    repeat (300) @(negedge clk);
    applyStimulus(200, rand_duty(), rand_duty(), PWM_MAX);
    wait_ps("lastwins_boundary");
    snap = exp_active;
    measure(hi, len);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (hi[ch] !== snap[ch] * CLK_PER_TICK) begin
        failures++;
        $display("[TB] FAIL lastwins_hi ch%0d: got %0d expected %0d", ch, hi[ch], snap[ch] * CLK_PER_TICK);
      end
    end
  endtask

  task automatic test_boundary_load();
    int hi [NUM_CH];
    int snap [NUM_CH];
    int len;
    int g2, b2;
    // Starts on a periodStart sample; the next boundary edge is PERIOD_CLK clk later.
    repeat (100) @(negedge clk);
    applyStimulus(20, rand_duty(), rand_duty(), PWM_MAX);
    repeat (PERIOD_CLK - 102) @(negedge clk);
    g2 = rand_duty();
    b2 = rand_duty();
    bus.dutyR    = duty_t'(50);
    bus.dutyG    = duty_t'(g2);
    bus.dutyB    = duty_t'(b2);
    bus.dutyW    = duty_t'(PWM_MAX);
    bus.dutyLoad = 1'b1;
    @(negedge clk);
    bus.dutyLoad = 1'b0;
    model_boundary();
    exp_shadow  = '{50, g2, b2, PWM_MAX};
    exp_pending = 1'b1;
    checks++;
    if (bus.periodStart !== 1'b1) begin
      failures++;
      $display("[TB] FAIL edge_periodStart: got %b expected 1", bus.periodStart);
    end
    checks++;
    if (bus.loadPending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL edge_pending_kept: got %b expected 1", bus.loadPending);
    end
    for (int p = 0; p < 2; p++) begin
      snap = exp_active;
      measure(hi, len);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        checks++;
        if (hi[ch] !== snap[ch] * CLK_PER_TICK) begin
          failures++;
          $display("[TB] FAIL edge_hi p%0d ch%0d: got %0d expected %0d", p, ch, hi[ch], snap[ch] * CLK_PER_TICK);
        end
      end
      checks++;
      if (bus.loadPending !== exp_pending) begin
        failures++;
        $display("[TB] FAIL edge_pending p%0d: got %b expected %b", p, bus.loadPending, exp_pending);
      end
    end
  endtask

  task automatic test_enable_drop();
    int hi [NUM_CH];
    int snap [NUM_CH];
    int len;
    int starts;
    int t0;
    repeat (500) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (pwm_bit(ch) !== 1'b0) begin
        failures++;
        $display("[TB] FAIL disable_pwm ch%0d: got %b expected 0", ch, pwm_bit(ch));
      end
    end
    starts = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.periodStart) starts++;
    end
    applyStimulus(rand_duty(), rand_duty(), rand_duty(), PWM_MAX);
    checks++;
    if (bus.loadPending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL disable_load_pending: got %b expected 1", bus.loadPending);
    end
    checks++;
    if (starts !== 0) begin
      failures++;
      $display("[TB] FAIL disable_periodStart: got %0d pulses expected 0", starts);
    end
    t0 = ticks;
    bus.enable = 1'b1;
    wait_ps("reenable_boundary");
    checks++;
    if (ticks - t0 !== PWM_MAX) begin
      failures++;
      $display("[TB] FAIL reenable_ticks: got %0d expected %0d", ticks - t0, PWM_MAX);
    end
    snap = exp_active;
    measure(hi, len);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (hi[ch] !== snap[ch] * CLK_PER_TICK) begin
        failures++;
        $display("[TB] FAIL reenable_hi ch%0d: got %0d expected %0d", ch, hi[ch], snap[ch] * CLK_PER_TICK);
      end
    end
  endtask

  task automatic test_reset_mid_period();
    int hi [NUM_CH];
    int snap [NUM_CH];
    int len;
    logic expW;
    repeat (300) @(negedge clk);
    applyStimulus(rand_duty(), rand_duty(), rand_duty(), rand_duty());
    expW = (exp_active[CH_W] == PWM_MAX) ? 1'b1 : 1'b0;
    checks++;
    if (bus.pwmW !== expW) begin
      failures++;
      $display("[TB] FAIL premid_pwmW: got %b expected %b", bus.pwmW, expW);
    end
    checks++;
    if (bus.loadPending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL premid_pending: got %b expected 1", bus.loadPending);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (pwm_bit(ch) !== 1'b0) begin
        failures++;
        $display("[TB] FAIL async_reset_pwm ch%0d: got %b expected 0", ch, pwm_bit(ch));
      end
    end
    checks++;
    if (bus.loadPending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_pending: got %b expected 0", bus.loadPending);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_ps("postreset_boundary");
    checks++;
    if (bus.loadPending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL postreset_pending: got %b expected 0", bus.loadPending);
    end
    snap = exp_active;
    measure(hi, len);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (hi[ch] !== snap[ch] * CLK_PER_TICK) begin
        failures++;
        $display("[TB] FAIL postreset_hi ch%0d: got %0d expected %0d", ch, hi[ch], snap[ch] * CLK_PER_TICK);
      end
    end
  endtask

  initial begin
    $display("[TB] rgbw_pwm_core bench start");
    test_reset();
    test_idle();
    test_basic_load();
    test_random_loads();
    test_last_load_wins();
    test_boundary_load();
    test_enable_drop();
    test_reset_mid_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgbw_pwm_core.md
Name: rgbw_pwm_core

Overview:
- Four-channel (R, G, B, W) PWM generator, directly downstream of the PWM clock prescaler.
- Consumes the prescaled clock `clkPresc` as a tick source in the system `clk` domain. It does not use `clkPresc` as a clock.
- Produces glitch-free PWM outputs. Duty updates are double-buffered and applied only at period boundaries.
- Feeds the LED driver pins.

Parameters:
- PWM_WIDTH, 8, duty/counter width in bits.
- PWM_MAX, 2**PWM_WIDTH-1 (255), last counter value plus one; the period is PWM_MAX ticks.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- clkPresc  input  1  prescaled clock from the divider, synchronous to clk; each rising edge is one PWM tick.
- enable  input  1  high = run; low = counter held at 0, outputs forced low.
- dutyR, dutyG, dutyB, dutyW  input  PWM_WIDTH each  requested duty values.
- dutyLoad  input  1  one-clk strobe; captures all four duty inputs into shadow registers.
- loadPending  output  1  high while shadow values await the next period boundary.
- periodStart  output  1  one-clk pulse when a new period begins (counter wraps to 0).
- pwmR, pwmG, pwmB, pwmW  output  1 each  registered PWM outputs.

Behaviour:
- Reset (reset=0, asynchronous):
  - counter=0; shadow and active duties = 0.
  - prescPrev=0, loadPending=0, periodStart=0, all pwm outputs = 0.
  - Release is synchronous-safe: the first tick can occur no earlier than the second clk edge after release.
- Tick detection:
  - prescPrev <= clkPresc every clk.
  - tick = clkPresc & ~prescPrev (rising edge only; exactly one clk wide).
  - With the standard divider (toggle every 3 clk), one tick occurs per 6 clk.
- Counter:
  - Advances only on (tick & enable).
  - Steps 0..PWM_MAX-1, then wraps to 0.
  - enable=0: counter <= 0 synchronously; periodStart not asserted.
- Period boundary = tick & enable & counter==PWM_MAX-1. On that cycle:
  - counter <= 0 and periodStart <= 1 for exactly one clk.
  - If loadPending=1: active <= shadow and loadPending <= 0.
- Load handshake:
  - dutyLoad=1: shadow <= duty inputs and loadPending <= 1.
  - Repeated loads before the boundary overwrite the shadow; last load wins.
  - dutyLoad on the same cycle as the boundary: active takes the old shadow (if pending). The new values go to shadow and loadPending stays 1, so they apply at the following boundary. No load is ever lost.
  - dutyLoad with enable=0: captured normally. Applied at the first boundary after enable returns high.
- Output:
  - pwmX <= enable & (counter < activeX), registered every clk; one clk latency from the counter.
  - duty 0 gives constant low. Duty PWM_MAX (255) gives constant high; no single-tick glitch at wrap.
  - Duty d gives high time of d ticks per PWM_MAX-tick period.
- Arithmetic: unsigned compare, PWM_WIDTH bits; the counter never reaches PWM_MAX.
- Reset mid-period: all state clears immediately; pending loads are discarded.

Decomposition:
- Package rgbw_pwm_pkg:
  - PWM_WIDTH and PWM_MAX constants.
  - Channel count NUM_CH=4 and channel index constants CH_R, CH_G, CH_B, CH_W.
- Sub-module pwm_channel, instantiated 4x:
  - Holds the shadow register, active register and compare/output flop for one channel.
  - Takes the shared counter, dutyLoad, apply strobe and enable.
- Counter, tick detection, loadPending and periodStart live in the top level.

Test Plan:
- Reset then release, clkPresc from a /6 divider, enable=1, no loads:
  - all pwm outputs stay 0.
  - periodStart pulses every 1530 clk (255 ticks × 6).
  - loadPending stays 0.
- dutyLoad with R=64, G=0, B=255, W=128:
  - loadPending=1 until the next periodStart, then 0.
  - Next period: pwmR high 384 clk of 1530, pwmG always 0, pwmB always 1 (no glitch at wrap), pwmW high 768 clk.
- Two loads in one period (R=10, then R=200):
  - the following period shows R high for 200 ticks (1200 clk).
  - value 10 never appears on the output.
- dutyLoad asserted exactly on the boundary cycle with R=50, shadow pending R=20:
  - next period R=20 and loadPending stays 1.
  - the period after that R=50.
- enable dropped mid-period:
  - outputs go low one clk later and the counter returns to 0.
  - re-enable: counter restarts from 0; first periodStart comes after 255 ticks.
- reset asserted mid-period with a load pending:
  - outputs and loadPending go 0 asynchronously, without waiting for a clk edge.
  - after release, PWM stays low until a new dutyLoad and boundary.
